// File: rtl/spi_slave_fsm_burst.sv
// SPI slave control FSM: decodes the serial-clock strobes of a frame into the
// address latch, shift register, data memory and MISO buffer enables, with an
// optional burst mode (address auto-increment) and mid-word framing-error pulse.
// Every output is a register loaded from the next state, so no input reaches an
// output combinationally.
module spi_slave_fsm_burst #(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned BURST_EN = 0
) (
   input  logic s_clk,
   input  logic rst_n,
   input  logic CS,
   input  logic sclk_pos,
   input  logic sclk_neg,
   input  logic read_write,
   output logic ad_we,
   output logic sr_we,
   output logic miso_buff,
   output logic dm_we,
   output logic addr_inc,
   output logic busy,
   output logic frame_err
);

   localparam int unsigned CMD_W = ADDR_W + 1;
   localparam int unsigned MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);
   // Terminal counts are compared before the increment, so the counter never
   // holds a value above MAX_W - 1.
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      StGet, StGot, StRead, StRead2, StRead3, StWrite, StWrite2, StDone
   } state_e;

   state_e           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_ad_we, r_sr_we, r_miso_buff, r_dm_we;
   logic             r_addr_inc, r_busy, r_frame_err;

   state_e           w_state_d;
   logic [CNT_W-1:0] w_count_d;
   logic             w_inc_d;
   logic             w_err_d;

   // Next-state, counter and pulse decode; CS high overrides everything.
   always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_inc_d   = 1'b0;
      w_err_d   = 1'b0;
      if (CS) begin
         w_state_d = StGet;
         w_count_d = '0;
         // Only a frame abandoned mid-word or mid-fetch is an error.
         w_err_d   = (((r_state == StGet) || (r_state == StRead3) || (r_state == StWrite)) &&
                      (r_count != '0)) || (r_state == StRead) || (r_state == StRead2);
      end else begin
         unique case (r_state)
            StGet: begin
               if (sclk_pos) begin
                  if (r_count == CMD_LAST) begin
                     w_state_d = StGot;
                     w_count_d = '0;
                  end else begin
                     w_count_d = r_count + 1'b1;
                  end
               end
            end
            StGot:    w_state_d = read_write ? StRead : StWrite;
            StRead:   w_state_d = StRead2;
            StRead2:  w_state_d = StRead3;
            StRead3: begin
               if (sclk_neg) begin
                  if (r_count == DATA_LAST) begin
                     w_count_d = '0;
                     if (BURST_EN != 0) begin
                        w_state_d = StRead;
                        w_inc_d   = 1'b1;
                     end else begin
                        w_state_d = StDone;
                     end
                  end else begin
                     w_count_d = r_count + 1'b1;
                  end
               end
            end
            StWrite: begin
               if (sclk_pos) begin
                  if (r_count == DATA_LAST) begin
                     w_state_d = StWrite2;
                     w_count_d = '0;
                  end else begin
                     w_count_d = r_count + 1'b1;
                  end
               end
            end
            StWrite2: begin
               if (BURST_EN != 0) begin
                  w_state_d = StWrite;
                  w_inc_d   = 1'b1;
               end else begin
                  w_state_d = StDone;
               end
            end
            StDone:   w_state_d = StDone;
            default:  w_state_d = StGet;
         endcase
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge s_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StGet;
         r_count     <= '0;
         r_ad_we     <= 1'b0;
         r_sr_we     <= 1'b0;
         r_miso_buff <= 1'b0;
         r_dm_we     <= 1'b0;
         r_addr_inc  <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_count     <= w_count_d;
         r_ad_we     <= (w_state_d == StGot);
         r_sr_we     <= (w_state_d == StRead2);
         r_miso_buff <= (w_state_d == StRead3);
         r_dm_we     <= (w_state_d == StWrite2);
         r_addr_inc  <= w_inc_d;
         r_busy      <= !((w_state_d == StGet) && (w_count_d == '0));
         r_frame_err <= w_err_d;
      end
   end

   assign ad_we     = r_ad_we;
   assign sr_we     = r_sr_we;
   assign miso_buff = r_miso_buff;
   assign dm_we     = r_dm_we;
   assign addr_inc  = r_addr_inc;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;

endmodule

// File: doc/spi_slave_fsm_burst.md
Name: spi_slave_fsm_burst

Overview:
- Parametrised successor to the SPI slave control FSM, driving the write enables for the address latch, shift register and data memory, plus the MISO buffer enable.
- Generalised address and data widths; optional burst mode with address auto-increment; framing-error detection.
- Runs on the system clock and consumes serial-clock edge strobes from the input conditioners.
- Sits between the input conditioners / shift register and the address latch / data memory.

Parameters:
- ADDR_W, 7, address bits per command; command length CMD_W = ADDR_W+1 (address then R/W bit).
- DATA_W, 8, data bits per word.
- BURST_EN, 0, 1 = after each word, auto-increment the address and continue while CS stays low; 0 = one word per frame.
- CNT_W, derived, $clog2(max(CMD_W,DATA_W)+1), bit-counter width.

Ports:
- s_clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- CS  input  1  chip select, active low (1 = deselected).
- sclk_pos  input  1  one-cycle strobe: serial clock rising edge.
- sclk_neg  input  1  one-cycle strobe: serial clock falling edge.
- read_write  input  1  R/W bit (shift register LSB); 1 = read.
- ad_we  output  1  address latch write enable.
- sr_we  output  1  shift register parallel-load enable.
- miso_buff  output  1  MISO tri-state enable.
- dm_we  output  1  data memory write enable.
- addr_inc  output  1  one-cycle pulse: address latch increment (burst only).
- busy  output  1  high in any state other than GET with count 0.
- frame_err  output  1  one-cycle pulse: CS deasserted mid-word.

Behaviour:
- Reset (rst_n=0, async): state=GET, count=0; all outputs 0. Releasing reset mid-frame leaves the FSM in GET, counting from 0.
- All outputs are decoded from the registered state/count; no combinational path from inputs to outputs.
- States: GET, GOT, READ, READ2, READ3, WRITE, WRITE2, DONE.
- GET: count increments on each sclk_pos. When count reaches CMD_W, go to GOT and clear count.
- GOT (1 cycle): ad_we=1. Next state is READ if read_write=1, else WRITE.
- READ (1 cycle): memory latency wait; no outputs.
- READ2 (1 cycle): sr_we=1.
- READ3: miso_buff=1; count increments on sclk_neg. At count=DATA_W, clear count; go to READ with addr_inc=1 for 1 cycle if BURST_EN, else go to DONE.
- WRITE: count increments on sclk_pos. At count=DATA_W, clear count and go to WRITE2.
- WRITE2 (1 cycle): dm_we=1. Next state is WRITE with addr_inc=1 for 1 cycle if BURST_EN, else DONE.
- DONE: all outputs 0; sclk strobes ignored until CS=1.
- CS=1 sampled in any state:
  - next state GET, count=0; overrides every other transition.
  - frame_err pulses for 1 cycle if the state was GET with count>0, READ3/WRITE with count>0, or READ/READ2.
  - No error when CS rises from DONE, from GET with count 0, or at a word boundary in burst mode.
  - dm_we is never issued for a partial word.
- sclk_pos and sclk_neg asserted together: only the strobe relevant to the current state counts.
- Strobes arriving in the single-cycle states (GOT/READ/READ2/WRITE2) are ignored; the master guarantees ≥3 s_clk cycles per serial half-period.
- Counter never exceeds max(CMD_W,DATA_W); no wrap.

Test Plan:
- Defaults; reset; CS low; 8 sclk_pos with R/W=0; then 8 sclk_pos -> ad_we exactly 1 cycle after 8th command edge; dm_we exactly 1 cycle after 8th data edge; then DONE, busy stays 1 until CS high.
- Defaults; read command (R/W=1) -> ad_we, then one idle cycle, then sr_we 1 cycle; miso_buff high for exactly 8 sclk_neg; then DONE with miso_buff=0.
- BURST_EN=1; write command + 3×8 data bits; CS high on word boundary -> 3 dm_we pulses; addr_inc after words 1, 2 and 3; frame_err=0.
- BURST_EN=1, ADDR_W=15, DATA_W=16; read burst of 2 words -> ad_we after 16 edges; sr_we twice; miso_buff spans 16 sclk_neg per word.
- CS high after 4 write data bits -> frame_err 1 cycle; no dm_we; next frame decodes normally from count 0.
- rst_n low during READ3 -> all outputs 0 immediately; after release, state GET and busy=0.
